// File: rtl/riscv_fetch_pkg.sv
// Shared types and constants for the fetch stage.
// Used by the RTL and by the bench.
package riscv_fetch_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    DONE = 1'b1
  } fetch_state_e;

  localparam int unsigned INST_BYTES = 4;

  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] DEF_PROG_END = 32'd24;

endpackage

// File: rtl/fetch_pc_gen.sv
// Program counter register and next-PC selection.
// Tracks sticky misaligned-redirect flag.
module fetch_pc_gen
  import riscv_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        advance,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] pc,
  output logic        misalign_err
);

  logic [31:0] pc_d, pc_q;
  logic        err_d, err_q;

  // Redirect wins; otherwise step by one word or hold.
  always_comb begin
    pc_d  = pc_q;
    err_d = err_q;
    if (redirect) begin
      pc_d  = {redirect_pc[31:2], 2'b00};
      err_d = err_q | (|redirect_pc[1:0]);
    end else if (advance) begin
      pc_d = pc_q + 32'(INST_BYTES);
    end
  end

  // PC and error flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q  <= RESET_PC;
      err_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      err_q <= err_d;
    end
  end

  assign pc           = pc_q;
  assign misalign_err = err_q;

endmodule

// File: rtl/inst_fetch.sv
// Fetch stage: PC, output register to decode,
// run/done control and handshake counter.
module inst_fetch
  import riscv_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC,
  parameter logic [31:0] PROG_END = DEF_PROG_END
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] PC,
  input  logic [31:0] inst,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst,
  output logic        done,
  output logic        misalign_err,
  output logic [15:0] fetch_count
);

  fetch_state_e state_d, state_q;
  logic         ov_d, ov_q;
  logic [31:0]  opc_d, opc_q;
  logic [31:0]  oinst_d, oinst_q;
  logic [15:0]  cnt_d, cnt_q;

  logic        fire;
  logic        load;
  logic        in_range;
  logic        advance;
  logic [31:0] tgt;

  fetch_pc_gen #(
    .RESET_PC (RESET_PC)
  ) u_pc_gen (
    .clk          (clk),
    .rst          (rst),
    .advance      (advance),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .pc           (PC),
    .misalign_err (misalign_err)
  );

  // Next-state for output register, FSM and counter.
  always_comb begin
    fire     = ov_q && out_ready;
    in_range = PC < PROG_END;
    tgt      = redirect_pc & ~32'd3;
    load     = (state_q == RUN) && (!ov_q || out_ready)
               && !redirect;
    advance  = load && in_range;
    state_d  = state_q;
    ov_d     = ov_q;
    opc_d    = opc_q;
    oinst_d  = oinst_q;
    cnt_d    = cnt_q + {15'd0, fire};
    if (redirect) begin
      ov_d    = 1'b0;
      state_d = (tgt < PROG_END) ? RUN : DONE;
    end else if (load) begin
      if (in_range) begin
        ov_d    = 1'b1;
        opc_d   = PC;
        oinst_d = inst;
      end else begin
        ov_d    = 1'b0;
        state_d = DONE;
      end
    end else if (fire) begin
      ov_d = 1'b0;
    end
  end

  // Registered outputs and control state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      ov_q    <= 1'b0;
      opc_q   <= 32'd0;
      oinst_q <= 32'd0;
      cnt_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      ov_q    <= ov_d;
      opc_q   <= opc_d;
      oinst_q <= oinst_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_valid   = ov_q;
  assign out_pc      = opc_q;
  assign out_inst    = oinst_q;
  assign done        = (state_q == DONE);
  assign fetch_count = cnt_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed plan steps,
// then random traffic against a transaction model.
module tb_inst_fetch;
  import riscv_fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] PC;
  logic [31:0] inst;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic        done;
  logic        misalign_err;
  logic [15:0] fetch_count;

  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0] prog [6];

  // model state
  logic [31:0] m_nxt;
  bit          m_have;
  logic [31:0] m_opc;
  logic [31:0] m_oinst;
  bit          m_stop;
  bit          m_err;
  logic [15:0] m_cnt;

  always #5 clk = ~clk;

  inst_fetch dut (
    .clk          (clk),
    .rst          (rst),
    .PC           (PC),
    .inst         (inst),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_pc       (out_pc),
    .out_inst     (out_inst),
    .done         (done),
    .misalign_err (misalign_err),
    .fetch_count  (fetch_count)
  );

  function automatic logic [31:0] word_at(
    input logic [31:0] a);
    if (a < DEF_PROG_END) return prog[a[4:2]];
    return 32'h0000_0013;
  endfunction

  assign inst = word_at(PC);

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_nxt   = DEF_RESET_PC;
    m_have  = 0;
    m_opc   = 0;
    m_oinst = 0;
    m_stop  = 0;
    m_err   = 0;
    m_cnt   = 0;
  endtask

  // One clock of the fetch rules, using current inputs.
  task automatic model_edge();
    bit fire;
    if (rst) begin
      model_reset();
      return;
    end
    fire = m_have && out_ready;
    if (fire) m_cnt = m_cnt + 16'd1;
    if (redirect) begin
      m_have = 0;
      m_nxt  = redirect_pc & ~32'd3;
      if (redirect_pc % 4 != 0) m_err = 1;
      m_stop = (m_nxt >= DEF_PROG_END);
    end else if (!m_stop && (!m_have || out_ready)) begin
      if (m_nxt < DEF_PROG_END) begin
        m_have  = 1;
        m_opc   = m_nxt;
        m_oinst = word_at(m_nxt);
        m_nxt   = m_nxt + 4;
      end else begin
        m_have = 0;
        m_stop = 1;
      end
    end else if (fire) begin
      m_have = 0;
    end
  endtask

  task automatic check_model();
    chk("pc", PC, m_nxt);
    chk("valid", 32'(out_valid), 32'(m_have));
    chk("done", 32'(done), 32'(m_stop));
    chk("misalign", 32'(misalign_err), 32'(m_err));
    chk("count", 32'(fetch_count), 32'(m_cnt));
    if (m_have) begin
      chk("out_pc", out_pc, m_opc);
      chk("out_inst", out_inst, m_oinst);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_model();
  endtask

  logic [15:0] c0;
  bit          hit;

  initial begin
    prog[0] = 32'h00E6_0433;
    prog[1] = 32'h40B6_0533;
    prog[2] = 32'hFCE0_8793;
    prog[3] = 32'h0081_2703;
    prog[4] = 32'h00E1_2423;
    prog[5] = 32'h00A9_8863;
    model_reset();
    rst         = 1;
    redirect    = 0;
    redirect_pc = 0;
    out_ready   = 1;
    step();
    step();
    chk("rst_pc", PC, 32'h0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_out_pc", out_pc, 32'h0);
    chk("rst_out_inst", out_inst, 32'h0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_cnt", 32'(fetch_count), 32'd0);

    // straight-line program
    rst = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("seq_pc", out_pc, 32'(i * 4));
      chk("seq_inst", out_inst, prog[i]);
      chk("seq_valid", 32'(out_valid), 32'd1);
    end
    step();
    chk("end_valid", 32'(out_valid), 32'd0);
    chk("end_done", 32'(done), 32'd1);
    chk("end_cnt", 32'(fetch_count), 32'd6);

    // restart, then backpressure on pc 8
    redirect = 1; redirect_pc = 32'h0;
    step();
    redirect = 0;
    step();
    step();
    step();
    chk("bp_pc8", out_pc, 32'd8);
    out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_hold_pc", out_pc, 32'd8);
      chk("bp_hold_inst", out_inst, 32'hFCE0_8793);
      chk("bp_hold_v", 32'(out_valid), 32'd1);
      chk("bp_PC", PC, 32'd12);
    end
    out_ready = 1;
    step();
    chk("bp_next", out_pc, 32'd12);

    // redirect during handshake of pc 16
    step();
    chk("rd_at16", out_pc, 32'd16);
    c0 = fetch_count;
    redirect = 1; redirect_pc = 32'd4;
    step();
    chk("rd_cnt", 32'(fetch_count), 32'(c0 + 16'd1));
    chk("rd_valid", 32'(out_valid), 32'd0);
    chk("rd_PC", PC, 32'd4);
    redirect = 0;
    step();
    chk("rd_out_pc", out_pc, 32'd4);
    chk("rd_out_inst", out_inst, 32'h40B6_0533);

    // run to DONE, then redirect back to 8
    hit = 0;
    for (int i = 0; i < 20 && !hit; i++) begin
      step();
      hit = done;
    end
    chk("to_done", 32'(hit), 32'd1);
    redirect = 1; redirect_pc = 32'd8;
    step();
    chk("dr_done", 32'(done), 32'd0);
    redirect = 0;
    step();
    chk("dr_out_pc", out_pc, 32'd8);
    chk("dr_valid", 32'(out_valid), 32'd1);

    // misaligned redirect, then out-of-range redirect
    redirect = 1; redirect_pc = 32'h0000_000E;
    step();
    chk("ma_err", 32'(misalign_err), 32'd1);
    redirect = 0;
    step();
    chk("ma_out_pc", out_pc, 32'd12);
    redirect = 1; redirect_pc = 32'h40;
    step();
    redirect = 0;
    step();
    chk("far_done", 32'(done), 32'd1);
    chk("far_valid", 32'(out_valid), 32'd0);
    chk("ma_sticky", 32'(misalign_err), 32'd1);

    // reset mid-stream, under backpressure and redirect
    redirect = 1; redirect_pc = 32'd0;
    step();
    redirect = 0;
    step();
    step();
    out_ready = 0;
    rst = 1; redirect = 1; redirect_pc = 32'd8;
    step();
    chk("mr_valid", 32'(out_valid), 32'd0);
    chk("mr_PC", PC, 32'd0);
    chk("mr_out_pc", out_pc, 32'd0);
    chk("mr_err", 32'(misalign_err), 32'd0);
    chk("mr_cnt", 32'(fetch_count), 32'd0);
    rst = 0; redirect = 0; out_ready = 1;
    step();
    chk("mr_first_pc", out_pc, 32'd0);
    chk("mr_first_inst", out_inst, 32'h00E6_0433);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      rst       = ($urandom_range(0, 79) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      redirect  = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 3) == 0)
        redirect_pc = $urandom_range(0, 40);
      else
        redirect_pc = 32'($urandom_range(0, 7) * 4);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction fetch stage and the initiator side of the instruction-memory read interface. It owns the program counter, drives the fetch address to the combinational instruction memory, and captures the returned word. It then presents {pc, inst} to decode over a valid/ready handshake. It also takes branch/jump redirects from execute and stops fetching at the end of the loaded program.

## Interface
- RESET_PC, 32'h0000_0000: first fetch address after reset.
- PROG_END, 32'd24: first byte address past the program; addresses ≥ PROG_END are never issued to decode.
- clk  input  1: single clock, rising edge.
- rst  input  1: synchronous, active-high reset.
- PC  output  32: fetch address to instruction memory; equals internal pc_r.
- inst  input  32: instruction word from memory, combinationally valid for the current PC in the same cycle.
- redirect  input  1: execute requests a fetch redirect (taken branch/jump).
- redirect_pc  input  32: redirect target, sampled when redirect=1.
- out_valid  output  1: out_pc/out_inst hold a valid fetched instruction.
- out_ready  input  1: decode accepts; handshake occurs when out_valid && out_ready.
- out_pc  output  32: address of the presented instruction.
- out_inst  output  32: presented instruction word.
- done  output  1: high while in state DONE.
- misalign_err  output  1: sticky; set by a redirect with redirect_pc[1:0] != 0.
- fetch_count  output  16: number of completed decode handshakes, wraps at 16'hFFFF→0.

## Operation
- State machine: RUN, DONE.
  - RUN → DONE when a load would use pc_r ≥ PROG_END.
  - DONE → RUN only on redirect with aligned target < PROG_END.
  - redirect to target ≥ PROG_END forces DONE.
- Load condition: load = (state==RUN) && (!out_valid || out_ready) && !redirect.
- On load with pc_r < PROG_END: out_pc ← pc_r; out_inst ← inst; out_valid ← 1; pc_r ← pc_r + 4 (32-bit, wraps modulo 2^32).
- On load attempt with pc_r ≥ PROG_END: out_valid ← 0; pc_r unchanged; state ← DONE.
- Handshake without load (DONE or redirect): out_valid ← 0.
- out_valid && !out_ready: out_pc, out_inst and out_valid hold. pc_r holds. No fetch is lost.
- Redirect, highest priority:
  - pc_r ← {redirect_pc[31:2], 2'b00}; out_valid ← 0 (flush).
  - A handshake completing in the same cycle still counts in fetch_count.
  - If redirect_pc[1:0] != 0, misalign_err ← 1, and it stays 1 until rst.
- fetch_count increments by 1 on every cycle with out_valid && out_ready.

## Timing
- Reset values: pc_r = PC = RESET_PC; out_valid = 0; out_pc = 0; out_inst = 0; state = RUN; done = 0; misalign_err = 0; fetch_count = 0.
- rst asserted mid-operation overrides redirect and handshake in that cycle. Any in-flight instruction is discarded and not counted.
- First valid instruction is on the first rising edge after rst is low. out_valid is high in cycle 1 after reset release.
- Throughput: 1 instruction/cycle while out_ready=1.
- Redirect penalty: redirect in cycle N gives out_valid=0 in N+1, with PC=target in N+1. The target instruction is valid in N+2.
- done asserts the cycle after the load attempt at PROG_END. out_valid is 0 from that cycle on.
- All outputs are registered except PC, which is pc_r directly with no combinational path from inputs.

## Structure
- Shared package riscv_fetch_pkg holds:
  - the state enum {RUN, DONE};
  - INST_BYTES = 4;
  - the default RESET_PC and PROG_END constants, reused by the top level and the bench.
- One natural sub-module, fetch_pc_gen: holds pc_r and implements the next-PC mux (hold / +4 / redirect with alignment masking and the misalignment flag).
- The output register, state machine and counter stay in inst_fetch.

## Test plan
- Reset release with out_ready=1 held, memory loaded with the six-word test program:
  - expect out_pc 0,4,8,12,16,20 with out_inst 0x00E60433, 0x40B60533, 0xFCE08793, 0x00812703, 0x00E12423, 0x00A98863 on consecutive cycles;
  - then out_valid=0, done=1, fetch_count=6.
- Backpressure: out_ready=0 for 3 cycles while out_pc=8 is presented. Expect out_pc=8, out_inst=0xFCE08793, out_valid=1 stable and PC=12. On release, 12 follows next cycle with no skip or duplicate.
- Redirect to 4 in the same cycle as the handshake of out_pc=16:
  - fetch_count counts the 16 handshake;
  - next cycle out_valid=0 and PC=4;
  - following cycle out_pc=4, out_inst=0x40B60533.
- Redirect from DONE to 8: state returns to RUN, out_pc=8 two cycles later, done=0.
- Misaligned redirect to 0x0000000E: misalign_err=1 (sticky), next out_pc=12; redirect to 0x40 gives DONE with out_valid=0.
- rst pulsed mid-stream with out_valid=1, out_ready=0: all outputs return to reset values. The first post-reset instruction is out_pc=0, out_inst=0x00E60433.
